ifetch_buffer: RTL and testbench
================================

IFETCH_BUFFER -- requirements
Module: ifetch_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, prefetch queue entries (power of two, ≥2).
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port imem_req  output  1  fetch request strobe to instruction memory.
REQ-006 SHALL have port imem_a  output  32  byte address of requested word.
REQ-007 SHALL have port imem_rvalid  input  1  read data valid, exactly one cycle after imem_req.
REQ-008 SHALL have port imem_rd  input  32  instruction word returned.
REQ-009 SHALL have port instr_valid  output  1  queue head holds a valid instruction.
REQ-010 SHALL have port instr  output  32  head instruction word.
REQ-011 SHALL have port instr_pc  output  32  address of head instruction.
REQ-012 SHALL have port instr_ready  input  1  CPU consumes head when high with instr_valid.
REQ-013 SHALL have port redirect  input  1  branch/jump taken; flush and refetch.
REQ-014 SHALL have port redirect_pc  input  32  new fetch address, sampled when redirect=1.

Function
REQ-015 SHALL implement states BOOT, FETCH, FULL, FLUSH.
REQ-016 BOOT: entered on reset; no request; unconditional transition to FETCH next cycle.
REQ-017 FETCH: SHALL assert imem_req with imem_a=fetch_pc when count+inflight < DEPTH, then fetch_pc += 4.
REQ-018 Request decision SHALL use registered count/inflight of current cycle; same-cycle pop not credited.
REQ-019 FETCH->FULL when count+inflight reaches DEPTH; FULL->FETCH when a pop frees a slot; no request in FULL.
REQ-020 Data with imem_rvalid=1 SHALL be pushed with its address; push and pop in same cycle legal.
REQ-021 Handshake: pop only when instr_valid && instr_ready; instr/instr_pc stable while valid and not popped.
REQ-022 instr_valid SHALL equal (count != 0); latency req→instr_valid = 2 cycles from empty queue.
REQ-023 redirect=1 (any state) SHALL empty queue, set fetch_pc=redirect_pc, enter FLUSH; redirect beats pop and push same cycle.
REQ-024 FLUSH: SHALL discard a response already in flight, issue no request, return to FETCH next cycle; first new request at redirect_pc.
REQ-025 redirect during FLUSH SHALL reload fetch_pc and remain in FLUSH one more cycle.
REQ-026 fetch_pc SHALL wrap 32'hFFFF_FFFC → 32'h0000_0000; queue pointers wrap modulo DEPTH.
REQ-027 imem_a SHALL be word-aligned; redirect_pc[1:0] ignored (forced 0).
REQ-028 imem_rvalid with no request outstanding SHALL be ignored.

Reset
REQ-029 rst_n low SHALL immediately force: state=BOOT, fetch_pc=RESET_PC, count=0, inflight=0, pointers=0.
REQ-030 Outputs under reset: imem_req=0, imem_a=0, instr_valid=0, instr=0, instr_pc=0.
REQ-031 Reset mid-operation SHALL drop queue contents and any in-flight response.

Structure
REQ-032 Package ifetch_pkg SHALL hold state enum, ADDR_W=32, INSTR_W=32, NOP word 32'h0.
REQ-033 Queue SHALL be sub-module ifetch_fifo (data+pc storage, push/pop/flush, count).

Verification
REQ-034 Reset, instr_ready=1 always, memory returns addr>>2 → instr_pc 0,4,8,… and instr 0,1,2,… each cycle, first valid cycle 3 after rst_n rises.
REQ-035 instr_ready=0 → exactly DEPTH(4) requests issued, then imem_req=0; raising instr_ready resumes fetch from 0x10.
REQ-036 redirect=1, redirect_pc=0x100 with one response in flight → response dropped, queue empty, next imem_a=0x100 two cycles later.
REQ-037 RESET_PC=32'hFFFF_FFF8 → imem_a sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-038 rst_n pulled low while queue holds 3 entries → instr_valid=0 same cycle; after release fetch restarts at RESET_PC.
REQ-039 redirect and pop same cycle with full queue → queue empty, no instruction delivered from old stream.

Source files
------------

// File: rtl/ifetch_pkg.sv
// ---------------------------------------------------------------------------
// ifetch_pkg
// Shared types and constants for the instruction prefetch buffer.
//   ADDR_W / INSTR_W : address and instruction word widths
//   NOP_WORD         : value presented on instr when no instruction is valid
//   fetch_state_e    : fetch controller states
//   word_align()     : clears the byte-offset bits of an address
// ---------------------------------------------------------------------------
package ifetch_pkg;

    localparam int ADDR_W  = 32;
    localparam int INSTR_W = 32;

    localparam logic [INSTR_W-1:0] NOP_WORD = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_BOOT,
        ST_FETCH,
        ST_FULL,
        ST_FLUSH
    } fetch_state_e;

    function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
        return {addr[ADDR_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/ifetch_fifo.sv
// ---------------------------------------------------------------------------
// ifetch_fifo
// Prefetch queue holding instruction words together with their addresses.
//   clk, rst_n          : clock, asynchronous active-low reset
//   push, push_data,
//   push_pc             : write one entry at the tail
//   pop                 : retire the head entry
//   flush               : drop all entries (wins over push/pop)
//   head_data, head_pc  : current head entry (meaningful when count != 0)
//   count               : number of stored entries (0..DEPTH)
// The parent guarantees no push when full and no pop when empty.
// ---------------------------------------------------------------------------
module ifetch_fifo
    import ifetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [INSTR_W-1:0]         push_data,
    input  logic [ADDR_W-1:0]          push_pc,
    input  logic                       pop,
    input  logic                       flush,
    output logic [INSTR_W-1:0]         head_data,
    output logic [ADDR_W-1:0]          head_pc,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [INSTR_W-1:0] data_mem [DEPTH];
    logic [ADDR_W-1:0]  pc_mem   [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;

    // Storage carries no reset; validity is tracked by count alone.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            data_mem[wr_ptr] <= push_data;
            pc_mem[wr_ptr]   <= push_pc;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    assign head_data = data_mem[rd_ptr];
    assign head_pc   = pc_mem[rd_ptr];

endmodule

// File: rtl/ifetch_buffer.sv
// ---------------------------------------------------------------------------
// ifetch_buffer
// Instruction prefetch buffer: issues sequential word fetches to instruction
// memory (fixed one-cycle read latency), queues the returned words with their
// addresses and hands them to the CPU through a valid/ready handshake.
// A redirect flushes the queue and restarts fetching at a new address.
//   clk, rst_n                  : clock, asynchronous active-low reset
//   imem_req, imem_a            : fetch request strobe and word address
//   imem_rvalid, imem_rd        : read response, one cycle after imem_req
//   instr_valid, instr, instr_pc: head of the queue towards the CPU
//   instr_ready                 : CPU accepts the head this cycle
//   redirect, redirect_pc       : taken branch/jump and its target
// ---------------------------------------------------------------------------
module ifetch_buffer
    import ifetch_pkg::*;
#(
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic                imem_req,
    output logic [ADDR_W-1:0]   imem_a,
    input  logic                imem_rvalid,
    input  logic [INSTR_W-1:0]  imem_rd,
    output logic                instr_valid,
    output logic [INSTR_W-1:0]  instr,
    output logic [ADDR_W-1:0]   instr_pc,
    input  logic                instr_ready,
    input  logic                redirect,
    input  logic [ADDR_W-1:0]   redirect_pc
);

    localparam int              CNT_W     = $clog2(DEPTH) + 1;
    localparam int              OCC_W     = CNT_W + 1;
    localparam logic [OCC_W-1:0] OCC_DEPTH = OCC_W'(DEPTH);

    fetch_state_e       state;
    fetch_state_e       state_next;
    logic [ADDR_W-1:0]  fetch_pc;
    logic [ADDR_W-1:0]  inflight_pc;
    logic               inflight;
    logic               req;
    logic               push;
    logic               pop;
    logic [CNT_W-1:0]   count;
    logic [OCC_W-1:0]   occupancy;
    logic [OCC_W-1:0]   occupancy_next;
    logic [INSTR_W-1:0] head_data;
    logic [ADDR_W-1:0]  head_pc;

    ifetch_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (imem_rd),
        .push_pc   (inflight_pc),
        .pop       (pop),
        .flush     (redirect),
        .head_data (head_data),
        .head_pc   (head_pc),
        .count     (count)
    );

    // Occupancy reserves a slot for the outstanding request so the queue
    // can never be overrun by a returning response.
    assign occupancy      = OCC_W'(count) + OCC_W'(inflight);
    assign occupancy_next = OCC_W'(count) + OCC_W'(push) - OCC_W'(pop) + OCC_W'(req);

    // A redirect kills both the response arriving now and the head pop.
    assign push = inflight && imem_rvalid && !redirect;
    assign pop  = instr_valid && instr_ready && !redirect;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_BOOT;
        end else begin
            state <= state_next;
        end
    end

    // FULL is left as soon as a pop frees a slot; redirect overrides all.
    always_comb begin
        state_next = state;
        case (state)
            ST_BOOT:  state_next = ST_FETCH;
            ST_FETCH: if (occupancy_next >= OCC_DEPTH) state_next = ST_FULL;
            ST_FULL:  if (occupancy_next < OCC_DEPTH) state_next = ST_FETCH;
            ST_FLUSH: state_next = ST_FETCH;
            default:  state_next = ST_BOOT;
        endcase
        if (redirect) begin
            state_next = ST_FLUSH;
        end
    end

    // The request decision looks only at registered occupancy; a pop in the
    // same cycle is credited on the following cycle.
    always_comb begin
        req = 1'b0;
        if (state == ST_FETCH && !redirect && occupancy < OCC_DEPTH) begin
            req = 1'b1;
        end
        imem_req = req;
        imem_a   = req ? fetch_pc : '0;
    end

    // inflight mirrors last cycle's request, matching the fixed memory latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc    <= word_align(RESET_PC);
            inflight    <= 1'b0;
            inflight_pc <= '0;
        end else begin
            inflight <= req;
            if (req) begin
                inflight_pc <= fetch_pc;
            end
            if (redirect) begin
                fetch_pc <= word_align(redirect_pc);
            end else if (req) begin
                fetch_pc <= fetch_pc + 32'd4;
            end
        end
    end

    assign instr_valid = (count != '0);
    assign instr       = instr_valid ? head_data : NOP_WORD;
    assign instr_pc    = instr_valid ? head_pc : '0;

endmodule

// File: tb/tb_ifetch_buffer.sv
// ---------------------------------------------------------------------------
// tb_ifetch_buffer
// Directed bench for ifetch_buffer. The memory model answers every request
// one cycle later with (address >> 2). A second instance with a high
// RESET_PC exercises fetch address wrap-around.
// ---------------------------------------------------------------------------
module tb_ifetch_buffer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_a;
    logic        imem_rvalid;
    logic        mem_rvalid = 1'b0;
    logic        stray;
    logic [31:0] imem_rd = 32'h0;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;
    logic        redirect;
    logic [31:0] redirect_pc;

    logic        hi_req;
    logic [31:0] hi_a;
    logic        hi_valid;
    logic [31:0] hi_instr;
    logic [31:0] hi_pc;

    int total = 0;
    int bad   = 0;
    int nreq;

    always #5 clk = ~clk;

    ifetch_buffer #(
        .DEPTH    (4),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_a      (imem_a),
        .imem_rvalid (imem_rvalid),
        .imem_rd     (imem_rd),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_ready (instr_ready),
        .redirect    (redirect),
        .redirect_pc (redirect_pc)
    );

    ifetch_buffer #(
        .DEPTH    (4),
        .RESET_PC (32'hFFFF_FFF8)
    ) dut_hi (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (hi_req),
        .imem_a      (hi_a),
        .imem_rvalid (1'b0),
        .imem_rd     (32'h0),
        .instr_valid (hi_valid),
        .instr       (hi_instr),
        .instr_pc    (hi_pc),
        .instr_ready (1'b1),
        .redirect    (1'b0),
        .redirect_pc (32'h0)
    );

    // Memory model: one-cycle latency, data = word index. stray injects an
    // unsolicited response.
    always @(posedge clk) begin
        mem_rvalid <= imem_req;
        imem_rd    <= imem_a >> 2;
    end
    assign imem_rvalid = mem_rvalid | stray;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic rdy, input logic redir, input logic [31:0] rpc, input logic str);
        instr_ready = rdy;
        redirect    = redir;
        redirect_pc = rpc;
        stray       = str;
        #1;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #2;
    endtask

    // Holds reset over one edge and releases it; the cycle after return is BOOT.
    task automatic restart(input logic rdy);
        rst_n = 1'b0;
        applyStimulus(rdy, 1'b0, 32'h0, 1'b0);
        nextCycle();
        rst_n = 1'b1;
        applyStimulus(rdy, 1'b0, 32'h0, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
        checkOutput("rst_req",   32'(imem_req), 32'h0);
        checkOutput("rst_a",     imem_a, 32'h0);
        checkOutput("rst_valid", 32'(instr_valid), 32'h0);
        checkOutput("rst_instr", instr, 32'h0);
        checkOutput("rst_pc",    instr_pc, 32'h0);
        nextCycle();
        nextCycle();

        // Streaming with instr_ready held high
        rst_n = 1'b1;
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
        checkOutput("boot_req", 32'(imem_req), 32'h0);
        nextCycle();
        checkOutput("s1_req1", 32'(imem_req), 32'h1);
        checkOutput("s1_a1",   imem_a, 32'h0);
        checkOutput("hi_a1",   hi_a, 32'hFFFF_FFF8);
        nextCycle();
        checkOutput("s1_a2",    imem_a, 32'h4);
        checkOutput("s1_valid2", 32'(instr_valid), 32'h0);
        checkOutput("hi_a2",    hi_a, 32'hFFFF_FFFC);
        nextCycle();
        checkOutput("hi_a3", hi_a, 32'h0000_0000);
        for (int k = 0; k < 6; k++) begin
            checkOutput($sformatf("s1_valid_%0d", k), 32'(instr_valid), 32'h1);
            checkOutput($sformatf("s1_instr_%0d", k), instr, 32'(k));
            checkOutput($sformatf("s1_pc_%0d", k), instr_pc, 32'(4 * k));
            nextCycle();
        end

        // Back-pressure: exactly four requests, then resume at 0x10
        restart(1'b0);
        nreq = 0;
        for (int c = 1; c <= 8; c++) begin
            nextCycle();
            if (imem_req) nreq++;
        end
        checkOutput("s2_nreq",  32'(nreq), 32'd4);
        checkOutput("s2_head",  instr, 32'h0);
        checkOutput("s2_hpc",   instr_pc, 32'h0);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
        checkOutput("s2_nocredit", 32'(imem_req), 32'h0);
        nextCycle();
        checkOutput("s2_resume_req", 32'(imem_req), 32'h1);
        checkOutput("s2_resume_a",   imem_a, 32'h10);
        checkOutput("s2_instr1",     instr, 32'h1);
        checkOutput("s2_pc1",        instr_pc, 32'h4);

        // Reset while three entries are queued and one response is in flight
        restart(1'b0);
        for (int c = 1; c <= 5; c++) nextCycle();
        checkOutput("s3_pre_valid", 32'(instr_valid), 32'h1);
        rst_n = 1'b0;
        #1;
        checkOutput("s3_rst_valid", 32'(instr_valid), 32'h0);
        checkOutput("s3_rst_instr", instr, 32'h0);
        checkOutput("s3_rst_pc",    instr_pc, 32'h0);
        nextCycle();
        rst_n = 1'b1;
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
        checkOutput("s3_boot_valid", 32'(instr_valid), 32'h0);
        nextCycle();
        checkOutput("s3_a1",     imem_a, 32'h0);
        checkOutput("s3_valid1", 32'(instr_valid), 32'h0);
        nextCycle();
        nextCycle();
        checkOutput("s3_valid3", 32'(instr_valid), 32'h1);
        checkOutput("s3_pc3",    instr_pc, 32'h0);

        // Redirect with a response in flight, then a double redirect
        restart(1'b1);
        nextCycle();
        nextCycle();
        applyStimulus(1'b1, 1'b1, 32'h100, 1'b0);
        checkOutput("s4_redir_req", 32'(imem_req), 32'h0);
        nextCycle();
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
        checkOutput("s4_flush_req",   32'(imem_req), 32'h0);
        checkOutput("s4_flush_valid", 32'(instr_valid), 32'h0);
        nextCycle();
        checkOutput("s4_new_req", 32'(imem_req), 32'h1);
        checkOutput("s4_new_a",   imem_a, 32'h100);
        nextCycle();
        checkOutput("s4_new_a2",  imem_a, 32'h104);
        nextCycle();
        checkOutput("s4_valid",   32'(instr_valid), 32'h1);
        checkOutput("s4_instr",   instr, 32'h40);
        checkOutput("s4_pc",      instr_pc, 32'h100);
        nextCycle();
        applyStimulus(1'b1, 1'b1, 32'h180, 1'b0);
        nextCycle();
        applyStimulus(1'b1, 1'b1, 32'h203, 1'b0);
        checkOutput("s4_f1_req",   32'(imem_req), 32'h0);
        checkOutput("s4_f1_valid", 32'(instr_valid), 32'h0);
        nextCycle();
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
        checkOutput("s4_f2_req", 32'(imem_req), 32'h0);
        nextCycle();
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
        checkOutput("s4_stray_valid", 32'(instr_valid), 32'h0);
        checkOutput("s4_r2_req",      32'(imem_req), 32'h1);
        checkOutput("s4_r2_a",        imem_a, 32'h200);
        nextCycle();
        checkOutput("s4_r2_a2", imem_a, 32'h204);
        nextCycle();
        checkOutput("s4_r2_pc",    instr_pc, 32'h200);
        checkOutput("s4_r2_instr", instr, 32'h80);

        // Redirect and pop together on a full queue
        restart(1'b0);
        for (int c = 1; c <= 6; c++) nextCycle();
        checkOutput("s5_full_req", 32'(imem_req), 32'h0);
        checkOutput("s5_full_pc",  instr_pc, 32'h0);
        nextCycle();
        applyStimulus(1'b1, 1'b1, 32'h400, 1'b0);
        nextCycle();
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
        checkOutput("s5_flush_valid", 32'(instr_valid), 32'h0);
        checkOutput("s5_flush_req",   32'(imem_req), 32'h0);
        nextCycle();
        checkOutput("s5_a",      imem_a, 32'h400);
        checkOutput("s5_valid1", 32'(instr_valid), 32'h0);
        nextCycle();
        checkOutput("s5_valid2", 32'(instr_valid), 32'h0);
        nextCycle();
        checkOutput("s5_valid3", 32'(instr_valid), 32'h1);
        checkOutput("s5_pc",     instr_pc, 32'h400);
        checkOutput("s5_instr",  instr, 32'h100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
